// File: rtl/game_ctrl_if.sv
// game_ctrl_if
// Sound request channel between the game controller and the audio block.
//   sound_req  : request pending, held until the audio block acknowledges
//   sound_type : UI_PRESS=0, NEXTLEVEL=1, CRASH=2, CELEBRATION=3
//   sound_ack  : audio block accepted the pending request
// The master modport is the game controller, the slave modport the audio block.
interface game_ctrl_if;
    logic       sound_req;
    logic [1:0] sound_type;
    logic       sound_ack;

    modport master (
        output sound_req,
        output sound_type,
        input  sound_ack
    );

    modport slave (
        input  sound_req,
        input  sound_type,
        output sound_ack
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl
// Input conditioning and top-level game FSM for the frog game.
// Four raw push-buttons are synchronised, debounced and turned into
// single-cycle press ticks.  The MENU/PLAYING/DEAD/WIN FSM tracks the
// level, and every FSM event posts a sound request to the audio block.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   btn_{up,down,left,right}_raw  raw buttons, asynchronous to clk
//   collision                     frog overlaps a hazard (level)
//   goal_reached                  frog entered the goal row (pulse)
//   state                         MENU=0, PLAYING=1, DEAD=2, WIN=3
//   level                         current level, 0 in MENU
//   btn_*_tick, any_key_tick      one-cycle debounced press pulses
//   snd                           sound req/type/ack channel (master)
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int NUM_LEVELS      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up_raw,
    input  logic        btn_down_raw,
    input  logic        btn_left_raw,
    input  logic        btn_right_raw,
    input  logic        collision,
    input  logic        goal_reached,
    output logic [1:0]  state,
    output logic [3:0]  level,
    output logic        btn_up_tick,
    output logic        btn_down_tick,
    output logic        btn_left_tick,
    output logic        btn_right_tick,
    output logic        any_key_tick,
    game_ctrl_if.master snd
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        LAST_LVL  = 4'(NUM_LEVELS);

    // The state encoding is decoded directly by the HUD, so it is fixed.
    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } sound_t;

    // Button bit order everywhere: 0=up, 1=down, 2=left, 3=right.
    logic [3:0]            raw_vec;
    logic [3:0]            sync_a;
    logic [3:0]            sync_b;
    logic [3:0]            deb;
    logic [3:0]            deb_prev;
    logic [3:0]            tick_vec;
    logic [3:0][CNT_W-1:0] cnt;
    logic                  any_tick;

    state_t                st;
    logic [HOLD_W-1:0]     hold;

    assign raw_vec = {btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

    // Two-flop synchroniser, then a per-button run-length counter: the
    // debounced value only flips after the synchronised input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle
    // restarts the count, so short glitches never reach the debounced value.
    // The tick is the registered rising edge of the debounced value, so a
    // release produces nothing and a held button ticks exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            tick_vec <= '0;
            any_tick <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_a   <= raw_vec;
            sync_b   <= sync_a;
            deb_prev <= deb;
            tick_vec <= deb & ~deb_prev;
            any_tick <= |(deb & ~deb_prev);
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_up_tick    = tick_vec[0];
    assign btn_down_tick  = tick_vec[1];
    assign btn_left_tick  = tick_vec[2];
    assign btn_right_tick = tick_vec[3];
    assign any_key_tick   = any_tick;
    assign state          = st;

    // Game FSM plus the sound request register. collision and goal_reached
    // come from logic already clocked by clk, so they are sampled directly.
    // The hold timer runs freely and is only meaningful in DEAD/WIN, where
    // it is zeroed on entry and saturates at HOLD_CYCLES-1.
    // The ack-clear is written first so that an event in the same cycle
    // overrides it: the old request completes and the new one stays raised
    // (latest event wins, nothing is queued).
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= MENU;
            level          <= '0;
            hold           <= '0;
            snd.sound_req  <= 1'b0;
            snd.sound_type <= UI_PRESS;
        end else begin
            if (snd.sound_req && snd.sound_ack) begin
                snd.sound_req <= 1'b0;
            end
            if (hold != HOLD_LAST) begin
                hold <= hold + HOLD_W'(1);
            end

            unique case (st)
                MENU: begin
                    if (any_tick) begin
                        st             <= PLAYING;
                        level          <= 4'd1;
                        snd.sound_req  <= 1'b1;
                        snd.sound_type <= UI_PRESS;
                    end
                end
                PLAYING: begin
                    if (collision) begin
                        st             <= DEAD;
                        hold           <= '0;
                        snd.sound_req  <= 1'b1;
                        snd.sound_type <= CRASH;
                    end else if (goal_reached) begin
                        snd.sound_req <= 1'b1;
                        if (level == LAST_LVL) begin
                            st             <= WIN;
                            hold           <= '0;
                            snd.sound_type <= CELEBRATION;
                        end else begin
                            level          <= level + 4'd1;
                            snd.sound_type <= NEXTLEVEL;
                        end
                    end
                end
                DEAD, WIN: begin
                    if (any_tick && hold == HOLD_LAST) begin
                        st             <= MENU;
                        level          <= '0;
                        snd.sound_req  <= 1'b1;
                        snd.sound_type <= UI_PRESS;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl
// Directed bench for game_ctrl with a behavioural reference model.
// The model tracks raw-button history windows, an elapsed-time view of the
// DEAD/WIN hold, and the latest-wins sound request; a compare process checks
// every DUT output against it on each falling edge, and the directed
// sequence adds hand-computed expectations at the interesting cycles.
module tb_game_ctrl;

    localparam int DB  = 4;
    localparam int HC  = 8;
    localparam int NL  = 3;

    logic       clk;
    logic       rst;
    logic [3:0] raw;
    logic       collision;
    logic       goal;
    logic       ack;

    logic [1:0] state;
    logic [3:0] level;
    logic       up_tick;
    logic       down_tick;
    logic       left_tick;
    logic       right_tick;
    logic       any_tick;

    int checks;
    int errors;

    game_ctrl_if snd_if ();
    assign snd_if.sound_ack = ack;

    game_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .NUM_LEVELS      (NL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_up_raw     (raw[0]),
        .btn_down_raw   (raw[1]),
        .btn_left_raw   (raw[2]),
        .btn_right_raw  (raw[3]),
        .collision      (collision),
        .goal_reached   (goal),
        .state          (state),
        .level          (level),
        .btn_up_tick    (up_tick),
        .btn_down_tick  (down_tick),
        .btn_left_tick  (left_tick),
        .btn_right_tick (right_tick),
        .any_key_tick   (any_tick),
        .snd            (snd_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, updated once per rising edge from the inputs
    int         m_state;
    int         m_level;
    int         m_type;
    logic       m_req;
    logic [3:0] m_tick;
    logic       m_any;
    logic [3:0] m_deb;
    logic [3:0] m_deb_prev;
    logic       rawq [4][DB+2];
    int         edge_no;
    int         m_entry;
    bit         model_ready;

    initial begin
        model_ready = 0;
        edge_no     = 0;
        forever begin
            @(posedge clk);
            edge_no++;
            if (rst) begin
                m_state    = 0;
                m_level    = 0;
                m_type     = 0;
                m_req      = 1'b0;
                m_tick     = '0;
                m_any      = 1'b0;
                m_deb      = '0;
                m_deb_prev = '0;
                m_entry    = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < DB + 2; j++)
                        rawq[i][j] = 1'b0;
            end else begin
                bit         fire;
                int         ev;
                logic [3:0] rise;
                fire = 0;
                ev   = 0;
                case (m_state)
                    0: if (m_any) begin
                        m_state = 1; m_level = 1; fire = 1; ev = 0;
                    end
                    1: if (collision) begin
                        m_state = 2; m_entry = edge_no; fire = 1; ev = 2;
                    end else if (goal) begin
                        fire = 1;
                        if (m_level == NL) begin
                            m_state = 3; m_entry = edge_no; ev = 3;
                        end else begin
                            m_level = m_level + 1; ev = 1;
                        end
                    end
                    default: if (m_any && (edge_no - 1 - m_entry) >= HC - 1) begin
                        m_state = 0; m_level = 0; fire = 1; ev = 0;
                    end
                endcase
                if (fire) begin
                    m_req  = 1'b1;
                    m_type = ev;
                end else if (m_req && ack) begin
                    m_req = 1'b0;
                end

                rise       = m_deb & ~m_deb_prev;
                m_deb_prev = m_deb;
                for (int i = 0; i < 4; i++) begin
                    bit all_differ;
                    for (int j = DB + 1; j > 0; j--)
                        rawq[i][j] = rawq[i][j-1];
                    rawq[i][0] = raw[i];
                    // the debounce logic sees raw two edges late; it flips
                    // after DB consecutive such samples disagree with it
                    all_differ = 1;
                    for (int j = 2; j < DB + 2; j++)
                        if (rawq[i][j] == m_deb[i]) all_differ = 0;
                    if (all_differ) m_deb[i] = ~m_deb[i];
                end
                m_tick = rise;
                m_any  = |rise;
            end
            model_ready = 1;
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                check_output("cyc_state", 8'(state), 8'(m_state));
                check_output("cyc_level", 8'(level), 8'(m_level));
                check_output("cyc_ticks",
                             8'({right_tick, left_tick, down_tick, up_tick}),
                             8'(m_tick));
                check_output("cyc_any", 8'(any_tick), 8'(m_any));
                check_output("cyc_req", 8'(snd_if.sound_req), 8'(m_req));
                check_output("cyc_type", 8'(snd_if.sound_type), 8'(m_type));
            end
        end
    end

    task automatic apply_stimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        apply_stimulus(1);
        ack = 1'b0;
    endtask

    task automatic goal_pulse();
        goal = 1'b1;
        apply_stimulus(1);
        goal = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        raw       = '0;
        collision = 1'b0;
        goal      = 1'b0;
        ack       = 1'b0;

        // reset state
        apply_stimulus(3);
        check_output("rst_state", 8'(state), 8'd0);
        check_output("rst_level", 8'(level), 8'd0);
        check_output("rst_req", 8'(snd_if.sound_req), 8'd0);
        check_output("rst_type", 8'(snd_if.sound_type), 8'd0);
        rst = 1'b0;
        apply_stimulus(2);

        // 3-cycle glitch: no tick, so the game never leaves MENU
        raw[0] = 1'b1;
        apply_stimulus(3);
        raw[0] = 1'b0;
        apply_stimulus(12);
        check_output("glitch_state", 8'(state), 8'd0);

        // steady press: tick in cycle 7 only
        raw[0] = 1'b1;
        apply_stimulus(6);
        check_output("deb_c6_tick", 8'(up_tick), 8'd0);
        apply_stimulus(1);
        check_output("deb_c7_tick", 8'(up_tick), 8'd1);
        check_output("deb_c7_any", 8'(any_tick), 8'd1);
        apply_stimulus(1);
        check_output("deb_c8_tick", 8'(up_tick), 8'd0);
        check_output("deb_start_state", 8'(state), 8'd1);
        apply_stimulus(10);
        raw[0] = 1'b0;
        apply_stimulus(10);

        // reset back to MENU with a request pending
        rst = 1'b1;
        apply_stimulus(1);
        check_output("rst2_state", 8'(state), 8'd0);
        check_output("rst2_req", 8'(snd_if.sound_req), 8'd0);
        rst = 1'b0;
        apply_stimulus(2);

        // start with right, hold ack low, then pulse it
        raw[3] = 1'b1;
        apply_stimulus(8);
        raw[3] = 1'b0;
        check_output("start_state", 8'(state), 8'd1);
        check_output("start_level", 8'(level), 8'd1);
        check_output("start_req", 8'(snd_if.sound_req), 8'd1);
        check_output("start_type", 8'(snd_if.sound_type), 8'd0);
        apply_stimulus(5);
        check_output("start_req_held", 8'(snd_if.sound_req), 8'd1);
        ack_pulse();
        check_output("start_req_clr", 8'(snd_if.sound_req), 8'd0);
        apply_stimulus(8);

        // level progression up to WIN
        goal_pulse();
        check_output("lvl2_level", 8'(level), 8'd2);
        check_output("lvl2_type", 8'(snd_if.sound_type), 8'd1);
        apply_stimulus(2);
        goal_pulse();
        check_output("lvl3_level", 8'(level), 8'd3);
        check_output("lvl3_type", 8'(snd_if.sound_type), 8'd1);
        apply_stimulus(2);
        goal_pulse();
        check_output("win_state", 8'(state), 8'd3);
        check_output("win_level", 8'(level), 8'd3);
        check_output("win_type", 8'(snd_if.sound_type), 8'd3);
        ack_pulse();
        check_output("win_req_clr", 8'(snd_if.sound_req), 8'd0);

        // leave WIN after the hold has expired
        apply_stimulus(10);
        raw[1] = 1'b1;
        apply_stimulus(8);
        raw[1] = 1'b0;
        check_output("win_exit_state", 8'(state), 8'd0);
        check_output("win_exit_level", 8'(level), 8'd0);
        check_output("win_exit_type", 8'(snd_if.sound_type), 8'd0);
        ack_pulse();
        apply_stimulus(8);

        // replay to level 2
        raw[2] = 1'b1;
        apply_stimulus(8);
        raw[2] = 1'b0;
        ack_pulse();
        apply_stimulus(8);
        goal_pulse();
        ack_pulse();
        apply_stimulus(2);

        // collision wins over goal; a tick at hold count 3 is ignored
        raw[2] = 1'b1;
        apply_stimulus(3);
        collision = 1'b1;
        goal      = 1'b1;
        apply_stimulus(1);
        collision = 1'b0;
        goal      = 1'b0;
        check_output("prio_state", 8'(state), 8'd2);
        check_output("prio_level", 8'(level), 8'd2);
        check_output("prio_type", 8'(snd_if.sound_type), 8'd2);
        apply_stimulus(3);
        check_output("hold3_tick", 8'(left_tick), 8'd1);
        apply_stimulus(1);
        check_output("hold3_state", 8'(state), 8'd2);
        raw[2]    = 1'b0;
        collision = 1'b1;
        apply_stimulus(1);
        collision = 1'b0;
        apply_stimulus(1);

        // exit DEAD with ack arriving in the same cycle as the new event
        raw[0] = 1'b1;
        apply_stimulus(7);
        check_output("dead_exit_tick", 8'(up_tick), 8'd1);
        ack = 1'b1;
        apply_stimulus(1);
        ack = 1'b0;
        raw[0] = 1'b0;
        check_output("dead_exit_state", 8'(state), 8'd0);
        check_output("dead_exit_level", 8'(level), 8'd0);
        check_output("ack_evt_req", 8'(snd_if.sound_req), 8'd1);
        check_output("ack_evt_type", 8'(snd_if.sound_type), 8'd0);
        ack_pulse();
        apply_stimulus(8);

        // reset mid-game at level 2 with a request pending, button held
        raw[3] = 1'b1;
        apply_stimulus(8);
        raw[3] = 1'b0;
        ack_pulse();
        apply_stimulus(8);
        goal_pulse();
        check_output("pre_rst_level", 8'(level), 8'd2);
        rst    = 1'b1;
        raw[1] = 1'b1;
        apply_stimulus(1);
        check_output("mid_rst_state", 8'(state), 8'd0);
        check_output("mid_rst_level", 8'(level), 8'd0);
        check_output("mid_rst_req", 8'(snd_if.sound_req), 8'd0);
        apply_stimulus(2);
        rst = 1'b0;
        apply_stimulus(6);
        check_output("held_c6_tick", 8'(down_tick), 8'd0);
        apply_stimulus(1);
        check_output("held_c7_tick", 8'(down_tick), 8'd1);
        apply_stimulus(1);
        check_output("held_c8_tick", 8'(down_tick), 8'd0);
        apply_stimulus(10);
        raw[1] = 1'b0;
        apply_stimulus(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
